// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares one synchronous single-port register file between two requesters:
//   requester 0 (two-wire serial slave register side) and requester 1
//   (parallel host/test port). One access is issued per cycle. Read data
//   comes back one cycle after the grant, flagged by that requester's rvalid.
//
//   Arbitration in NONE is round-robin on ties. A winner may lock ownership
//   (OWN0/OWN1) for a burst. A locked owner is forced out once it has held
//   ownership for MAX_HOLD cycles while the other requester waits.
//
//   Optional build macro ARB_FIXED_PRI_EN: a tie in NONE always goes to
//   requester 0. The one exception is the cycle right after a forced release,
//   which still goes to the requester that was kept waiting.
//
// Parameters
//   AW       address width
//   DW       data width
//   MAX_HOLD maximum locked cycles while the other requester waits (1..255)
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   rN_req/lock/we        requester N request, keep-ownership flag, write enable
//   rN_addr/wdata         requester N address and write data
//   rN_gnt                combinational grant: the access is issued this cycle
//   rN_rvalid             registered pulse: rd_data holds rN's read data
//   mem_en/we/addr/wdata  memory port
//   mem_rdata             memory read data, one cycle after the read strobe
//   rd_data               shared read data (equal to mem_rdata)
//   owner                 registered owner: 0 none, 1 requester 0, 2 requester 1
module regfile_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       g0, g1;
  logic       tie_to_1;
  logic       rv0_p1, rv1_p1;

`ifdef ARB_FIXED_PRI_EN
  // Set by a forced release so the waiting requester gets exactly one tie.
  logic       rel_pend, rel_pend_nxt;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef ARB_FIXED_PRI_EN
  // After a release by requester 0 (last = 0) the tie goes to requester 1;
  // a release by requester 1 leaves requester 0 winning the tie anyway.
  assign tie_to_1 = rel_pend & ~last;
`else
  assign tie_to_1 = ~last;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    g0        = 1'b0;
    g1        = 1'b0;
`ifdef ARB_FIXED_PRI_EN
    rel_pend_nxt = rel_pend;
`endif
    case (state)
      NONE: begin
`ifdef ARB_FIXED_PRI_EN
        rel_pend_nxt = 1'b0;
`endif
        g1 = r1_req & (~r0_req | tie_to_1);
        g0 = r0_req & ~g1;
        if (g0) begin
          last_nxt = 1'b0;
          if (r0_lock) begin
            state_nxt = OWN0;
            hold_nxt  = 8'd0;
          end
        end
        if (g1) begin
          last_nxt = 1'b1;
          if (r1_lock) begin
            state_nxt = OWN1;
            hold_nxt  = 8'd0;
          end
        end
      end
      OWN0: begin
        hold_nxt = sat_inc(hold_cnt);
        // Forced release wins over the owner's own request; the bubble cycle
        // lets NONE hand the next tie to the waiting requester.
        if ((hold_cnt >= MAX_HOLD_C) && r1_req) begin
          state_nxt = NONE;
          last_nxt  = 1'b0;
`ifdef ARB_FIXED_PRI_EN
          rel_pend_nxt = 1'b1;
`endif
        end else if (r0_req) begin
          g0 = 1'b1;
          if (!r0_lock) state_nxt = NONE;
        end else if (!r0_lock) begin
          state_nxt = NONE;
        end
      end
      OWN1: begin
        hold_nxt = sat_inc(hold_cnt);
        if ((hold_cnt >= MAX_HOLD_C) && r0_req) begin
          state_nxt = NONE;
          last_nxt  = 1'b1;
`ifdef ARB_FIXED_PRI_EN
          rel_pend_nxt = 1'b1;
`endif
        end else if (r1_req) begin
          g1 = 1'b1;
          if (!r1_lock) state_nxt = NONE;
        end else if (!r1_lock) begin
          state_nxt = NONE;
        end
      end
      default: state_nxt = NONE;
    endcase
  end

  // Grants are suppressed for the whole reset cycle so nothing reaches memory.
  assign r0_gnt    = g0 & ~rst;
  assign r1_gnt    = g1 & ~rst;
  assign mem_en    = r0_gnt | r1_gnt;
  assign mem_we    = (r0_gnt & r0_we) | (r1_gnt & r1_we);
  assign mem_addr  = g1 ? r1_addr  : r0_addr;
  assign mem_wdata = g1 ? r1_wdata : r0_wdata;

  // Stage p0 -> p1: grant cycle to read-data cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NONE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
      rv0_p1   <= 1'b0;
      rv1_p1   <= 1'b0;
`ifdef ARB_FIXED_PRI_EN
      rel_pend <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      rv0_p1   <= r0_gnt & ~r0_we;
      rv1_p1   <= r1_gnt & ~r1_we;
`ifdef ARB_FIXED_PRI_EN
      rel_pend <= rel_pend_nxt;
`endif
    end
  end

  assign r0_rvalid = rv0_p1;
  assign r1_rvalid = rv1_p1;
  assign rd_data   = mem_rdata;
  assign owner     = state;

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

`ifdef ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          r0_req, r0_lock, r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt, r0_rvalid;
  logic          r1_req, r1_lock, r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt, r1_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rd_data;
  logic [1:0]    owner;

  regfile_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_data(rd_data), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: untouched locations read as a fixed pattern of the address.
  bit [DW-1:0] wr_mem [256];
  bit          wr_vld [256];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {8'hC3, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_mem[mem_addr] <= mem_wdata;
        wr_vld[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wr_vld[mem_addr] ? wr_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (r0_rvalid || r1_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'({r1_rvalid, r0_rvalid}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rvalid_port", 32'({r1_rvalid, r0_rvalid}), e.port ? 32'd2 : 32'd1);
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end
    end
  end

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic push_rd(input logic port, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    #1;

    // Reset: a pending read is not granted and produces no rvalid
    r0_req = 1; r0_addr = 8'h05;
    sample();
    chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    rst = 0; r0_req = 0;
    sample();
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    next_cycle();

    // r0 write 0xBEEF to 0x10
    r0_req = 1; r0_we = 1; r0_addr = 8'h10; r0_wdata = 16'hBEEF;
    sample();
    chk("wr_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("wr_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("wr_owner", 32'(owner), 32'd0);
    next_cycle();
    r0_req = 0; r0_we = 0;
    sample();
    chk("wr_no_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    next_cycle();

    // r1 reads back 0x10
    r1_req = 1; r1_we = 0; r1_addr = 8'h10;
    sample();
    chk("rd_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    push_rd(1'b1, 16'hBEEF);
    next_cycle();
    r1_req = 0;
    sample();
    chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd0);
    next_cycle();
    sample();
    chk("rd_r1_rvalid_pulse", 32'(r1_rvalid), 32'd0);
    next_cycle();

    // Both requesting reads continuously: alternation (round-robin) or r0 always
    do_reset();
    r0_req = 1; r0_addr = 8'h20;
    r1_req = 1; r1_addr = 8'h21;
    for (int i = 0; i < 6; i++) begin
      logic w;
      w = FIXED ? 1'b0 : 1'(i % 2);
      sample();
      chk("alt_r0_gnt", 32'(r0_gnt), 32'(!w));
      chk("alt_r1_gnt", 32'(r1_gnt), 32'(w));
      push_rd(w, w ? init_val(8'h21) : init_val(8'h20));
      next_cycle();
    end
    r0_req = 0; r1_req = 0;
    sample();
    next_cycle();

    // Locked r0 burst of 4 reads while r1 waits
    do_reset();
    r1_req = 1; r1_addr = 8'h40;
    for (int k = 0; k < 4; k++) begin
      r0_req = 1; r0_lock = (k < 3); r0_addr = 8'(8'h30 + k);
      sample();
      chk("burst_r0_gnt", 32'(r0_gnt), 32'd1);
      chk("burst_r1_gnt", 32'(r1_gnt), 32'd0);
      chk("burst_owner", 32'(owner), (k == 0) ? 32'd0 : 32'd1);
      push_rd(1'b0, init_val(8'(8'h30 + k)));
      next_cycle();
    end
    r0_req = 0; r0_lock = 0;
    sample();
    chk("burst_after_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("burst_after_owner", 32'(owner), 32'd0);
    push_rd(1'b1, init_val(8'h40));
    next_cycle();
    r1_req = 0;
    sample();
    next_cycle();

    // Forced release with MAX_HOLD = 4
    do_reset();
    r0_req = 1; r0_lock = 1; r0_addr = 8'h50;
    r1_req = 1; r1_addr = 8'h60;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("hold_r0_gnt", 32'(r0_gnt), 32'd1);
      chk("hold_r1_gnt", 32'(r1_gnt), 32'd0);
      chk("hold_owner", 32'(owner), (k == 0) ? 32'd0 : 32'd1);
      push_rd(1'b0, init_val(8'h50));
      next_cycle();
    end
    sample();
    chk("release_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("release_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("release_mem_en", 32'(mem_en), 32'd0);
    chk("release_owner", 32'(owner), 32'd1);
    next_cycle();
    sample();
    chk("handoff_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("handoff_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("handoff_owner", 32'(owner), 32'd0);
    push_rd(1'b1, init_val(8'h60));
    next_cycle();
    r1_req = 0;
    sample();
    chk("regain_r0_gnt", 32'(r0_gnt), 32'd1);
    push_rd(1'b0, init_val(8'h50));
    next_cycle();
    r0_req = 0; r0_lock = 0;
    sample();
    chk("bubble_mem_en", 32'(mem_en), 32'd0);
    chk("bubble_owner", 32'(owner), 32'd1);
    next_cycle();
    sample();
    chk("bubble_after_owner", 32'(owner), 32'd0);
    next_cycle();

    // Reset while requester 1 owns the port with a read pending
    do_reset();
    r1_req = 1; r1_lock = 1; r1_we = 1; r1_addr = 8'h70; r1_wdata = 16'h1234;
    sample();
    chk("own1_r1_gnt", 32'(r1_gnt), 32'd1);
    next_cycle();
    r1_we = 0; r1_addr = 8'h71; rst = 1;
    sample();
    chk("own1_owner", 32'(owner), 32'd2);
    chk("own1_rst_gnt", 32'(r1_gnt), 32'd0);
    chk("own1_rst_mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    rst = 0; r1_req = 0; r1_lock = 0;
    sample();
    chk("postrst_owner", 32'(owner), 32'd0);
    chk("postrst_r1_rvalid", 32'(r1_rvalid), 32'd0);
    next_cycle();
    r0_req = 1; r0_addr = 8'h22;
    r1_req = 1; r1_addr = 8'h23;
    sample();
    chk("postrst_tie_r0", 32'(r0_gnt), 32'd1);
    chk("postrst_tie_r1", 32'(r1_gnt), 32'd0);
    push_rd(1'b0, init_val(8'h22));
    next_cycle();
    r0_req = 0; r1_req = 0;
    sample();
    next_cycle();
    sample();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-requester arbiter sharing one synchronous single-port register file (256 x 16 by default).
- Requester 0 is the two-wire serial slave's register-access side; requester 1 is the parallel host/test port.
- Per access cycle, the block selects one requester, drives the memory port, and returns read data one cycle later.
- Supports round-robin arbitration, locked bursts, and a forced release so a locked owner cannot starve the other requester.

Parameters:
- AW, 8: address width.
- DW, 16: data width.
- MAX_HOLD, 16: maximum cycles a locked owner keeps ownership while the other requester waits (range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- r0_req  in  1  requester 0 access request; level, held until granted.
- r0_lock  in  1  requester 0 asks to keep ownership after this access.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  AW  requester 0 address.
- r0_wdata  in  DW  requester 0 write data.
- r0_gnt  out  1  access issued this cycle (combinational).
- r0_rvalid  out  1  read data valid on rd_data (registered pulse).
- r1_req, r1_lock, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid: same as the r0_* ports, for requester 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe.
- rd_data  out  DW  equals mem_rdata; sampled by whichever requester has rvalid high.
- owner  out  2  0 = none, 1 = requester 0 locked, 2 = requester 1 locked (registered).

Behaviour:
- States: NONE, OWN0, OWN1. Registers:
  - last: last winner; reset value 1, so requester 0 wins the first tie.
  - hold_cnt: 8 bits.
  - rv0, rv1: rvalid registers.
- Reset (synchronous, any cycle, including mid-burst): state NONE, last = 1, hold_cnt = 0, r0_rvalid = r1_rvalid = 0, owner = 0. While rst is high, r0_gnt, r1_gnt, mem_en and mem_we are forced to 0. A read issued in the reset cycle returns no rvalid.
- NONE:
  - One request pending: grant it.
  - Both pending: grant the requester not equal to last.
  - The winner's request fields drive mem_*, with mem_en = 1 and last set to the winner.
  - If the winner's lock = 1: next state is OWNx and hold_cnt = 0.
  - No request pending: mem_en = 0 and mem_we = 0; mem_addr and mem_wdata are don't-care.
- OWNx (owner x, other requester y):
  - hold_cnt increments each cycle, saturating at 255.
  - Forced release takes priority: if hold_cnt >= MAX_HOLD and y_req = 1, x is not granted, the next state is NONE and last = x, so y wins next cycle.
  - Otherwise, if x_req = 1: grant x. If x_lock = 0, this is the final access and the next state is NONE; otherwise stay in OWNx.
  - Otherwise, if x_req = 0 and x_lock = 0: no grant, next state is NONE. One bubble cycle; y is not served in this cycle.
  - Otherwise (x_req = 0, x_lock = 1): no grant, stay in OWNx.
  - y is never granted while in OWNx.
- Read latency:
  - A grant with we = 0 in cycle N gives x_rvalid = 1 for exactly cycle N+1, with rd_data = mem_rdata.
  - Write grants produce no rvalid.
  - Back-to-back reads give a continuous rvalid stream: one grant per cycle, one pulse per grant.
- gnt depends combinationally on req/lock inputs and registered state only. There is no path from mem_rdata to gnt.
- owner reflects the registered state: NONE = 0, OWN0 = 1, OWN1 = 2.
- Requesters must hold req, we, addr and wdata stable until gnt. Behaviour when a requester drops req without having been granted is legal: nothing is issued.

Optional Feature:
- Macro ARB_FIXED_PRI_EN.
- When defined: in NONE, a tie always grants requester 0 and last is ignored. Locking and forced release are unchanged; forced release still hands exactly one access to requester 1 before requester 0 can win again.
- When not defined: round-robin as above.

Test Plan:
- Reset, then r0_req = 1, we = 1, addr = 0x10, wdata = 0xBEEF, lock = 0 → r0_gnt = 1 the same cycle; mem_en = 1, mem_we = 1, mem_addr = 0x10, mem_wdata = 0xBEEF; owner stays 0; no rvalid.
- r1 read of addr 0x10 with memory model returning 0xBEEF → r1_gnt in cycle N; r1_rvalid = 1 only in N+1 with rd_data = 0xBEEF; r0_rvalid stays 0.
- Both requesting continuously, lock = 0 → grants alternate r0, r1, r0, r1 (r0 first after reset). With ARB_FIXED_PRI_EN defined, r0 is granted every cycle.
- r0 locked burst of 4 reads (lock = 1 on the first 3, 0 on the 4th) while r1 requests → owner = 1 during the burst; 4 consecutive r0 grants; r1 granted the cycle after the last r0 grant.
- MAX_HOLD = 4, r0 holds lock = 1 with req = 1 indefinitely while r1 requests → r0 gets 5 grants (NONE cycle plus hold_cnt 0..3); the cycle with hold_cnt = 4 grants nobody; the next cycle r1 is granted; owner returns to 0.
- Assert rst during OWN1 with a read granted in the same cycle → next cycle owner = 0, no rvalid; the first tie afterwards goes to r0.
